// File: rtl/move_rec_pkg.sv
// Shared definitions for the move recorder and the display block.
// Holds move codes, list capacity, the FSM state type and the button
// priority decoder.
package move_rec_pkg;

  // Move codes packed two bits per move into the list
  localparam logic [1:0] MvDo = 2'd0;
  localparam logic [1:0] MvLe = 2'd1;
  localparam logic [1:0] MvUp = 2'd2;
  localparam logic [1:0] MvRi = 2'd3;

  localparam int unsigned MaxMv = 32;  // 64-bit list / 2 bits per move
  localparam int unsigned BtnW  = 5;   // [4] up, [3] down, [2] left, [1] right, [0] undo

  typedef enum logic [1:0] {
    StIdle,
    StAccept,
    StHold
  } state_e;

  typedef struct packed {
    logic       undo;
    logic [1:0] code;
  } act_t;

  // Highest-index button wins; undo only when no direction is pressed.
  function automatic act_t decode_btn(input logic [BtnW-1:0] b);
    act_t a;
    a.undo = 1'b0;
    a.code = MvDo;
    if (b[4])      a.code = MvUp;
    else if (b[3]) a.code = MvDo;
    else if (b[2]) a.code = MvLe;
    else if (b[1]) a.code = MvRi;
    else           a.undo = b[0];
    return a;
  endfunction

endpackage

// File: rtl/move_rec_btn_sync.sv
// Button conditioning for move_rec (the btn_sync block): 2-flop synchronizer
// followed by a register that only samples on prescaler wrap, which debounces.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   btn        : raw button bus
//   smp        : sampled (debounced) buttons, updated on wrap
//   tick       : one-cycle pulse in the cycle smp holds a fresh sample
module move_rec_btn_sync #(
  parameter int unsigned TICK_W = 12,
  parameter int unsigned BTN_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BTN_W-1:0] btn,
  output logic [BTN_W-1:0] smp,
  output logic             tick
);

  logic [BTN_W-1:0]  sync1_q, sync2_q, smp_q;
  logic [TICK_W-1:0] presc_q;
  logic              tick_q;
  logic              wrap;

  assign wrap = &presc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      smp_q   <= '0;
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      presc_q <= presc_q + 1'b1;
      tick_q  <= wrap;
      if (wrap) smp_q <= sync2_q;
    end
  end

  assign smp  = smp_q;
  assign tick = tick_q;

endmodule

// File: rtl/move_rec.sv
// Move recorder: debounces five buttons and keeps a packed list of up to
// MAX_MV two-bit moves. Optional undo on btn[0] when MOVE_REC_UNDO_EN is
// defined; otherwise btn[0] is ignored entirely.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   rec_en     : recording enable
//   clr        : synchronous clear of the list (forces HOLD)
//   btn        : raw buttons [4] up, [3] down, [2] left, [1] right, [0] undo
//   ord        : packed list, move i in bits [2i+1:2i]
//   cnt        : number of recorded moves
//   mv_valid   : one-cycle pulse per accepted move, mv_code its code
//   full       : list holds MAX_MV moves
module move_rec
  import move_rec_pkg::*;
#(
  parameter int unsigned TICK_W = 12,
  parameter int unsigned MAX_MV = MaxMv
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rec_en,
  input  logic            clr,
  input  logic [BtnW-1:0] btn,
  output logic [63:0]     ord,
  output logic [63:0]     cnt,
  output logic            mv_valid,
  output logic [1:0]      mv_code,
  output logic            full
);

  localparam int unsigned CntW = $clog2(MAX_MV + 1);
  localparam int unsigned PosW = 6;  // bit position within the 64-bit list

  logic [BtnW-1:0] smp, eff;
  logic            tick;
  act_t            act;
  state_e          state_q, state_d;
  logic [63:0]     ord_q, ord_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_m1;
  logic [PosW-1:0] wr_pos, un_pos;
  logic            is_full;

  move_rec_btn_sync #(
    .TICK_W (TICK_W),
    .BTN_W  (BtnW)
  ) u_btn_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn),
    .smp   (smp),
    .tick  (tick)
  );

`ifdef MOVE_REC_UNDO_EN
  assign eff = smp;
`else
  // Undo masked out so it can neither start a press nor keep HOLD busy
  assign eff = {smp[BtnW-1:1], 1'b0};
`endif

  assign act     = decode_btn(eff);
  assign is_full = (cnt_q == CntW'(MAX_MV));
  assign cnt_m1  = cnt_q - 1'b1;
  assign wr_pos  = PosW'({cnt_q, 1'b0});
  assign un_pos  = PosW'({cnt_m1, 1'b0});

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (tick && rec_en && (|eff)) state_d = StAccept;
      StAccept: state_d = StHold;
      StHold:   if (tick && !(|eff)) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (clr) state_d = StHold;
  end

  // Outputs and list update; clr overrides the action of an ACCEPT cycle
  always_comb begin
    mv_valid = 1'b0;
    mv_code  = MvDo;
    ord_d    = ord_q;
    cnt_d    = cnt_q;
    if (clr) begin
      ord_d = '0;
      cnt_d = '0;
    end else if (state_q == StAccept) begin
      if (!act.undo) begin
        if (!is_full) begin
          ord_d[wr_pos +: 2] = act.code;
          cnt_d              = cnt_q + 1'b1;
          mv_valid           = 1'b1;
          mv_code            = act.code;
        end
      end else if (cnt_q != '0) begin
        ord_d[un_pos +: 2] = 2'b00;
        cnt_d              = cnt_m1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ord_q <= '0;
      cnt_q <= '0;
    end else begin
      ord_q <= ord_d;
      cnt_q <= cnt_d;
    end
  end

  assign ord  = ord_q;
  assign cnt  = {{(64 - CntW){1'b0}}, cnt_q};
  assign full = is_full;

endmodule
